// File: rtl/voice_alloc_pkg.sv
// Shared constants for the voice allocator: received-word fields and FSM encoding.
package voice_alloc_pkg;

  localparam int         NOTE_W  = 7;
  localparam int         ON_BIT  = 7;
  localparam logic [7:0] ALL_OFF = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/voice_alloc_slot.sv
// One voice's registers: sounding flag, note code and saturating age counter.
module voice_slot
  import voice_alloc_pkg::*;
#(
  parameter int C_AGE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [NOTE_W-1:0]      load_note,
  input  logic                   clear,
  input  logic                   deact,
  input  logic                   retrig,
  input  logic                   inc,
  output logic                   active,
  output logic [NOTE_W-1:0]      note,
  output logic [C_AGE_WIDTH-1:0] age
);

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      note   <= '0;
      age    <= '0;
    end else if (clear) begin
      active <= 1'b0;
      age    <= '0;
    end else if (load) begin
      active <= 1'b1;
      note   <= load_note;
      age    <= '0;
    end else if (retrig) begin
      age <= '0;
    end else if (deact) begin
      // note is kept so the light path can still show the last pitch
      active <= 1'b0;
    end else if (inc && active && (age != '1)) begin
      age <= age + 1'b1;
    end
  end

endmodule

// File: rtl/voice_alloc.sv
// Voice allocator: accepts note words, scans the voices one per cycle, then commits.
module voice_alloc
  import voice_alloc_pkg::*;
#(
  parameter int C_UART_DATA_WIDTH = 8,
  parameter int C_VOICES          = 4,
  parameter int C_AGE_WIDTH       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         inValid,
  input  logic                         inErr,
  input  logic [C_UART_DATA_WIDTH-1:0] inData,
  output logic                         inReady,
  output logic [C_VOICES-1:0]          voiceActive,
  output logic [NOTE_W*C_VOICES-1:0]   voiceNote,
  output logic [C_VOICES-1:0]          voiceTrig,
  output logic                         voiceSteal,
  output logic [7:0]                   dropCnt
);

  localparam int              IDX_W    = (C_VOICES > 1) ? $clog2(C_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_VOICES - 1);

  state_t                        state_reg, state_next;
  logic [C_UART_DATA_WIDTH-1:0]  word_reg;
  logic [IDX_W-1:0]              idx_reg;
  logic                          match_found_reg, free_found_reg, old_found_reg;
  logic [IDX_W-1:0]              match_idx_reg, free_idx_reg, old_idx_reg;
  logic [C_AGE_WIDTH-1:0]        old_age_reg;
  logic [C_VOICES-1:0]           trig_reg;
  logic                          steal_reg;
  logic [7:0]                    drop_reg;

  logic                          slot_active [C_VOICES];
  logic [NOTE_W-1:0]             slot_note   [C_VOICES];
  logic [C_AGE_WIDTH-1:0]        slot_age    [C_VOICES];
  logic [C_VOICES-1:0]           load_v, clear_v, deact_v, retrig_v, inc_v;
  logic                          steal_next;

  logic              accept, drop, word_on, all_off;
  logic [NOTE_W-1:0] word_note;

  assign accept    = inValid && !inErr && (state_reg == IDLE);
  assign drop      = inValid && (inErr || (state_reg != IDLE));
  assign word_note = word_reg[NOTE_W-1:0];
  assign word_on   = word_reg[ON_BIT];
  assign all_off   = (word_reg == C_UART_DATA_WIDTH'(ALL_OFF));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = SCAN;
      SCAN:    if (idx_reg == LAST_IDX) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Decide the per-voice action for the latched word from the scan results.
  always_comb begin
    load_v     = '0;
    clear_v    = '0;
    deact_v    = '0;
    retrig_v   = '0;
    inc_v      = '0;
    steal_next = 1'b0;
    if (state_reg == COMMIT) begin
      if (all_off) begin
        clear_v = '1;
      end else if (word_on) begin
        if (match_found_reg) begin
          retrig_v[match_idx_reg] = 1'b1;
        end else begin
          if (free_found_reg) begin
            load_v[free_idx_reg] = 1'b1;
          end else begin
            load_v[old_idx_reg] = 1'b1;
            steal_next          = 1'b1;
          end
          inc_v = ~load_v;
        end
      end else if (match_found_reg) begin
        deact_v[match_idx_reg] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_reg        <= '0;
      idx_reg         <= '0;
      match_found_reg <= 1'b0;
      free_found_reg  <= 1'b0;
      old_found_reg   <= 1'b0;
      match_idx_reg   <= '0;
      free_idx_reg    <= '0;
      old_idx_reg     <= '0;
      old_age_reg     <= '0;
      trig_reg        <= '0;
      steal_reg       <= 1'b0;
      drop_reg        <= '0;
    end else begin
      trig_reg  <= load_v | retrig_v;
      steal_reg <= steal_next;
      if (drop && (drop_reg != 8'hFF)) drop_reg <= drop_reg + 8'd1;
      if (accept) begin
        word_reg        <= inData;
        idx_reg         <= '0;
        match_found_reg <= 1'b0;
        free_found_reg  <= 1'b0;
        old_found_reg   <= 1'b0;
      end
      if (state_reg == SCAN) begin
        idx_reg <= idx_reg + 1'b1;
        if (!match_found_reg && slot_active[idx_reg] && (slot_note[idx_reg] == word_note)) begin
          match_found_reg <= 1'b1;
          match_idx_reg   <= idx_reg;
        end
        if (!free_found_reg && !slot_active[idx_reg]) begin
          free_found_reg <= 1'b1;
          free_idx_reg   <= idx_reg;
        end
        // Strictly greater keeps the lowest index on equal ages.
        if (slot_active[idx_reg] && (!old_found_reg || (slot_age[idx_reg] > old_age_reg))) begin
          old_found_reg <= 1'b1;
          old_idx_reg   <= idx_reg;
          old_age_reg   <= slot_age[idx_reg];
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < C_VOICES; gi++) begin : g_slot
      voice_slot #(
        .C_AGE_WIDTH(C_AGE_WIDTH)
      ) u_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (load_v[gi]),
        .load_note(word_note),
        .clear    (clear_v[gi]),
        .deact    (deact_v[gi]),
        .retrig   (retrig_v[gi]),
        .inc      (inc_v[gi]),
        .active   (slot_active[gi]),
        .note     (slot_note[gi]),
        .age      (slot_age[gi])
      );
      assign voiceActive[gi]                  = slot_active[gi];
      assign voiceNote[NOTE_W*gi +: NOTE_W]   = slot_note[gi];
    end
  endgenerate

  assign inReady    = (state_reg == IDLE);
  assign voiceTrig  = trig_reg;
  assign voiceSteal = steal_reg;
  assign dropCnt    = drop_reg;

endmodule

// File: tb/tb_voice_alloc.sv
// Directed test-plan sequences plus random traffic, checked every cycle against a behavioural model.
module tb_voice_alloc;

  localparam int V  = 4;
  localparam int AW = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_err = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_ready;
  logic [V-1:0]     voice_active;
  logic [7*V-1:0]   voice_note;
  logic [V-1:0]     voice_trig;
  logic             voice_steal;
  logic [7:0]       drop_cnt;

  always #5 clk = ~clk;

  voice_alloc #(
    .C_UART_DATA_WIDTH(8),
    .C_VOICES         (V),
    .C_AGE_WIDTH      (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .inValid    (in_valid),
    .inErr      (in_err),
    .inData     (in_data),
    .inReady    (in_ready),
    .voiceActive(voice_active),
    .voiceNote  (voice_note),
    .voiceTrig  (voice_trig),
    .voiceSteal (voice_steal),
    .dropCnt    (drop_cnt)
  );

  int pass_cnt  = 0;
  int check_cnt = 0;
  bit check_en  = 1'b0;

  // Model: voice table plus a countdown of cycles until the pending word takes effect.
  int m_active [V];
  int m_note   [V];
  int m_age    [V];
  int m_busy  = 0;
  int m_word  = 0;
  int m_trig  = 0;
  int m_steal = 0;
  int m_drop  = 0;

  task automatic check(input string name, input int act, input int exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int dut_note(input int v);
    return int'((voice_note >> (7 * v)) & 28'h7F);
  endfunction

  task automatic model_commit();
    int n, on, hit, fr, old, maxage;
    n = m_word & 127;
    on = (m_word >> 7) & 1;
    hit = -1; fr = -1; old = -1;
    maxage = (1 << AW) - 1;
    if (m_word == 0) begin
      for (int i = 0; i < V; i++) begin m_active[i] = 0; m_age[i] = 0; end
      return;
    end
    for (int i = 0; i < V; i++) if (hit < 0 && m_active[i] != 0 && m_note[i] == n) hit = i;
    if (on == 0) begin
      if (hit >= 0) m_active[hit] = 0;
      return;
    end
    if (hit >= 0) begin
      m_age[hit] = 0;
      m_trig = 1 << hit;
      return;
    end
    for (int i = 0; i < V; i++) if (fr < 0 && m_active[i] == 0) fr = i;
    if (fr < 0) begin
      for (int i = 0; i < V; i++) if (old < 0 || m_age[i] > m_age[old]) old = i;
      m_steal = 1;
      fr = old;
    end
    for (int i = 0; i < V; i++)
      if (i != fr && m_active[i] != 0 && m_age[i] < maxage) m_age[i]++;
    m_note[fr] = n; m_active[fr] = 1; m_age[fr] = 0;
    m_trig = 1 << fr;
  endtask

  task automatic model_edge();
    m_trig = 0;
    m_steal = 0;
    if (rst) begin
      for (int i = 0; i < V; i++) begin m_active[i] = 0; m_note[i] = 0; m_age[i] = 0; end
      m_busy = 0; m_word = 0; m_drop = 0;
      return;
    end
    if (in_valid && (in_err || m_busy != 0) && m_drop < 255) m_drop++;
    if (m_busy != 0) begin
      m_busy--;
      if (m_busy == 0) model_commit();
    end else if (in_valid && !in_err) begin
      m_word = int'(in_data);
      m_busy = V + 1;
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      int ea, en;
      ea = 0; en = 0;
      for (int i = 0; i < V; i++) begin
        ea |= (m_active[i] != 0) ? (1 << i) : 0;
        en |= m_note[i] << (7 * i);
      end
      check("ready", int'(in_ready), (m_busy == 0) ? 1 : 0);
      check("active", int'(voice_active), ea);
      check("notes", int'(voice_note), en);
      check("trig", int'(voice_trig), m_trig);
      check("steal", int'(voice_steal), m_steal);
      check("drop", int'(drop_cnt), m_drop);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] w, input logic e);
    in_valid = 1'b1; in_err = e; in_data = w;
    tick();
    in_valid = 1'b0; in_err = 1'b0;
  endtask

  task automatic send_wait(input logic [7:0] w);
    send(w, 1'b0);
    idle(V + 1);
  endtask

  initial begin
    // 1: reset
    tick();
    check_en = 1'b1;
    idle(2);
    rst = 1'b0;
    tick();
    @(negedge clk);
    check("lit_rst_ready", int'(in_ready), 1);
    check("lit_rst_active", int'(voice_active), 0);
    check("lit_rst_notes", int'(voice_note), 0);
    check("lit_rst_drop", int'(drop_cnt), 0);
    check("lit_rst_trig", int'(voice_trig), 0);

    // 2: first note lands on voice 0 at edge V+1
    send_wait(8'hBC);
    @(negedge clk);
    check("lit_on_active", int'(voice_active), 1);
    check("lit_on_note0", dut_note(0), 60);
    check("lit_on_trig", int'(voice_trig), 1);
    tick();
    @(negedge clk);
    check("lit_on_trig_end", int'(voice_trig), 0);

    // 3: fill all voices then steal the oldest
    send_wait(8'hBE);
    send_wait(8'hC0);
    send_wait(8'hC1);
    send_wait(8'hC3);
    @(negedge clk);
    check("lit_steal", int'(voice_steal), 1);
    check("lit_steal_trig", int'(voice_trig), 1);
    check("lit_steal_note0", dut_note(0), 67);
    check("lit_steal_note1", dut_note(1), 62);
    check("lit_steal_note2", dut_note(2), 64);
    check("lit_steal_note3", dut_note(3), 65);

    // 4: retrigger, release, release of an unheld note
    send_wait(8'h00);
    send_wait(8'hBC);
    send_wait(8'hBE);
    send_wait(8'hBE);
    @(negedge clk);
    check("lit_retrig_trig", int'(voice_trig), 2);
    check("lit_retrig_active", int'(voice_active), 3);
    check("lit_retrig_steal", int'(voice_steal), 0);
    send_wait(8'h3E);
    @(negedge clk);
    check("lit_off_active", int'(voice_active), 1);
    check("lit_off_note1", dut_note(1), 62);
    send_wait(8'h45);
    @(negedge clk);
    check("lit_off_nomatch", int'(voice_active), 1);
    check("lit_off_nomatch_trig", int'(voice_trig), 0);

    // 5: drops and saturation, then all-notes-off
    send(8'hAA, 1'b1);
    send(8'hBC, 1'b0);
    in_valid = 1'b1; in_data = 8'hC5;
    tick();
    in_valid = 1'b0;
    idle(V);
    @(negedge clk);
    check("lit_drop2", int'(drop_cnt), 2);
    check("lit_drop_active", int'(voice_active), 1);
    in_valid = 1'b1; in_err = 1'b1;
    idle(260);
    in_valid = 1'b0; in_err = 1'b0;
    @(negedge clk);
    check("lit_drop_sat", int'(drop_cnt), 255);
    send_wait(8'h00);
    @(negedge clk);
    check("lit_alloff", int'(voice_active), 0);

    // 6: reset in the middle of a scan
    send(8'hBC, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("lit_midrst_ready", int'(in_ready), 1);
    check("lit_midrst_active", int'(voice_active), 0);
    for (int i = 0; i < V + 3; i++) begin
      tick();
      @(negedge clk);
      check("lit_midrst_notrig", int'(voice_trig), 0);
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      in_valid = ($urandom_range(0, 2) == 0);
      in_err   = ($urandom_range(0, 9) == 0);
      if (r == 0)      in_data = 8'h00;
      else if (r == 1) in_data = 8'h80;
      else             in_data = {($urandom_range(0, 2) != 0), 7'(58 + $urandom_range(0, 7))};
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; in_err = 1'b0;
    idle(V + 3);
    @(negedge clk);
    check_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/voice_alloc.md
Name: voice_alloc

Overview:
Voice allocator and scheduler between the UART receiver and the tone-generator/light datapath. It accepts note-on and note-off bytes from the UART Rx word stream. It shares C_VOICES tone-generator voices among incoming notes: it allocates a free voice, retriggers a held note, or steals the oldest voice when all voices are busy. The outputs are per-voice note/active/trigger signals consumed by the sound and light blocks.

Parameters:
C_UART_DATA_WIDTH, 8, width of the received word; bit [7] = on(1)/off(0), bits [6:0] = note code.
C_VOICES, 4, number of shared voices (2..8).
C_AGE_WIDTH, 4, width of each per-voice age counter; the counter saturates.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-high.
inValid  in  1  one-cycle strobe; a received word is present (from UART Rx valid).
inErr  in  1  the received word is invalid (framing error); qualifies inValid.
inData  in  C_UART_DATA_WIDTH  received word.
inReady  out  1  high while in IDLE; the block can accept a word.
voiceActive  out  C_VOICES  the voice is sounding.
voiceNote  out  7*C_VOICES  note code per voice; voice v occupies [7v+6:7v].
voiceTrig  out  C_VOICES  one-cycle pulse when a voice is (re)started.
voiceSteal  out  1  one-cycle pulse when an active voice was stolen.
dropCnt  out  8  count of dropped words; saturates at 255.

Behaviour:
- Reset: all outputs 0 except inReady=1; FSM goes to IDLE; ages 0; any latched word is discarded. A reset asserted in any state takes effect on the next edge.
- FSM states: IDLE, SCAN, COMMIT.
- IDLE:
  - inValid&!inErr: latch inData, idx<=0, go to SCAN.
  - inValid&inErr: dropCnt+1 (saturating); stay in IDLE.
- SCAN: examines voice idx each cycle and records:
  - first matching voice (active and note equal);
  - lowest-index free voice;
  - oldest active voice (max age; ties go to the lowest index).
  - At idx==C_VOICES-1, go to COMMIT.
- inValid outside IDLE: the word is dropped and dropCnt+1 (saturating). UART Rx has no backpressure, so no stall is applied.
- COMMIT (1 cycle, then IDLE):
  - Word 0x00 (off, note 0) is all-notes-off: all voiceActive<=0, ages<=0. No trig pulse.
  - Note-on, match found: retrigger. That voice's age<=0, trig pulse; no other change.
  - Note-on, no match, free voice: allocate the lowest free voice. Note<=code, active<=1, age<=0, trig pulse. Every other active voice's age +1 (saturating).
  - Note-on, no free voice: steal the oldest voice. Note<=code, age<=0, trig and voiceSteal pulses. Other ages +1 (saturating).
  - Note-off, match found: active<=0; voiceNote is held unchanged.
  - Note-off, no match: no change.
  - Note-on with note code 0 is a normal note.
- Latency: with the accept edge as cycle 0, outputs update at edge C_VOICES+1. voiceTrig/voiceSteal are high for exactly that one cycle. inReady=1 again on the following cycle; the next accept is possible at edge C_VOICES+2.
- Width rules:
  - Ages compare as unsigned values.
  - dropCnt never wraps.
  - Only bits [6:0] of inData select the note.

Decomposition:
- Shared package holds:
  - message field constants: ON bit index 7, NOTE field [6:0], ALL_OFF code 8'h00;
  - FSM state encoding;
  - note width 7.
- One sub-module is natural: voice_slot, per-voice registers (active, note, age) with load/clear/age-increment controls. It is instantiated C_VOICES times in a generate loop. The scan/compare logic and the FSM stay in voice_alloc.

Test Plan:
1. Reset held 3 cycles, then released -> voiceActive=0, voiceNote=0, dropCnt=0, inReady=1, no pulses.
2. inData=0xBC (on, note 60) -> at edge 5 (C_VOICES=4): voiceActive=4'b0001, voice0 note=60, voiceTrig=4'b0001 for 1 cycle.
3. On 0xBC, 0xBE, 0xC0, 0xC1 (60, 62, 64, 65), then 0xC3 (67) -> voice0 stolen: note 67, voiceSteal=1, voiceTrig=4'b0001. Voices 1-3 unchanged.
4. With 60 and 62 held:
   - 0xBE -> voice1 retriggered, voiceTrig=4'b0010, no new allocation;
   - 0x3E -> voice1 inactive;
   - 0x45 (off, note 69, not held) -> no change.
5. Word with inErr=1, and a word strobed during SCAN -> dropCnt=2, voice state unchanged. 260 error words -> dropCnt=255. Then 0x00 -> all voices inactive.
6. rst pulsed during SCAN of 0xBC -> next cycle IDLE, inReady=1, all voices inactive, no trig pulse ever emitted.
